// File: rtl/alu_op_decoder.sv
// Registered RV32I decode stage in front of the ALU: maps an instruction and its
// operands to an ALU control code plus arguments, behind a 2-entry skid buffer.
module alu_op_decoder #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_ctrl,
   output logic [XLEN-1:0] arg1,
   output logic [XLEN-1:0] arg2,
   output logic            cmp_sel,
   output logic            illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0010;
   localparam logic [3:0] ALU_SRA  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_CMPU = 4'b1000;
   localparam logic [3:0] ALU_CMPS = 4'b1001;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]      alu_ctrl;
      logic [XLEN-1:0] arg1;
      logic [XLEN-1:0] arg2;
      logic            cmp_sel;
      logic            illegal;
   } dec_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   dec_t            dec;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};

   // Register-index fields are resolved upstream; only their operand values arrive here.
   logic unused_reg_fields;
   assign unused_reg_fields = ^instr[19:15];

   function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      case (f3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_CMPS;
         3'b011:  code = ALU_CMPU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   always_comb begin
      // NOTE: every field gets a default before the case so no path infers a latch.
      dec = '0;
      case (opcode)
         OPC_OP: begin
            dec.alu_ctrl = f3_ctrl(funct3, funct7[5]);
            dec.cmp_sel  = (funct3 == 3'b010) || (funct3 == 3'b011);
            dec.arg1     = rs1_data;
            dec.arg2     = rs2_data;
            dec.illegal  = !((funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OPC_OP_IMM: begin
            dec.alu_ctrl = f3_ctrl(funct3, (funct3 == 3'b101) && funct7[5]);
            dec.cmp_sel  = (funct3 == 3'b010) || (funct3 == 3'b011);
            dec.arg1     = rs1_data;
            dec.arg2     = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? shamt : imm_i;
            dec.illegal  = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                           ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
         end
         OPC_LUI: begin
            dec.arg2 = imm_u;
         end
         OPC_AUIPC: begin
            dec.arg1 = pc;
            dec.arg2 = imm_u;
         end
         OPC_LOAD: begin
            dec.arg1 = rs1_data;
            dec.arg2 = imm_i;
         end
         OPC_STORE: begin
            dec.arg1 = rs1_data;
            dec.arg2 = imm_s;
         end
         default: dec.illegal = 1'b1;
      endcase
      // Unsupported encodings still flow downstream, but with a clean zero payload.
      if (dec.illegal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   dec_t out_q, out_d, skid_q, skid_d;
   logic out_valid_q, out_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_ready_q;
   logic accept, consume;

   assign accept  = in_valid && in_ready_q;
   assign consume = out_valid_q && out_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (consume && skid_valid_q) begin
         out_d        = skid_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!out_valid_q || consume)) begin
         out_d       = dec;
         out_valid_d = 1'b1;
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end else if (consume) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
      end
   end

   // NOTE: skid payload needs no reset; it is never observed unless skid_valid_q is set.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign alu_ctrl  = out_q.alu_ctrl;
   assign arg1      = out_q.arg1;
   assign arg2      = out_q.arg2;
   assign cmp_sel   = out_q.cmp_sel;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode vectors, back-to-back flow,
// backpressure through the skid buffer and reset behaviour.
module tb_alu_op_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [3:0]  alu_ctrl;
   logic [31:0] arg1;
   logic [31:0] arg2;
   logic        cmp_sel;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   // {out_valid, alu_ctrl, arg1, arg2, cmp_sel, illegal}
   logic [70:0] obs;
   assign obs = {out_valid, alu_ctrl, arg1, arg2, cmp_sel, illegal};

   alu_op_decoder #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_ctrl  (alu_ctrl),
      .arg1      (arg1),
      .arg2      (arg2),
      .cmp_sel   (cmp_sel),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Presents one instruction with out_ready=1 and returns just after the accepting edge.
   task automatic drive_one(input logic [31:0] i, input logic [31:0] p,
                            input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      instr     = i;
      pc        = p;
      rs1_data  = a;
      rs2_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      instr     = 32'h40208133;
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs !== 71'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h in_ready=%b, required outputs=0 in_ready=0", obs, in_ready);
         end
      end
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
      end
   endtask

   task automatic test_sub();
      drive_one(32'h40208133, 32'h0, 32'd5, 32'd7);
      checks++;
      if (obs !== {1'b1, 4'h1, 32'd5, 32'd7, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub: got %h, required %h", obs, {1'b1, 4'h1, 32'd5, 32'd7, 1'b0, 1'b0});
      end
   endtask

   task automatic test_srai();
      drive_one(32'h4030D093, 32'h0, 32'h80000000, 32'h0);
      checks++;
      if (obs !== {1'b1, 4'h3, 32'h80000000, 32'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL srai: got %h, required %h", obs, {1'b1, 4'h3, 32'h80000000, 32'd3, 1'b0, 1'b0});
      end
   endtask

   task automatic test_slti_neg_imm();
      drive_one(32'hFFF0A113, 32'h0, 32'h10, 32'h0);
      checks++;
      if (obs !== {1'b1, 4'h9, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL slti: got %h, required %h", obs, {1'b1, 4'h9, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0});
      end
   endtask

   task automatic test_auipc();
      drive_one(32'h12345017, 32'h100, 32'hDEAD, 32'hBEEF);
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h100, 32'h12345000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL auipc: got %h, required %h", obs, {1'b1, 4'h0, 32'h100, 32'h12345000, 1'b0, 1'b0});
      end
   endtask

   task automatic test_op_mix();
      drive_one(32'h0020F1B3, 32'h0, 32'h0000F0F0, 32'h0000FF00);   // and x3,x1,x2
      checks++;
      if (obs !== {1'b1, 4'h7, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL and: got %h, required %h", obs, {1'b1, 4'h7, 32'h0000F0F0, 32'h0000FF00, 1'b0, 1'b0});
      end
      drive_one(32'h0020B1B3, 32'h0, 32'h3, 32'h4);                 // sltu x3,x1,x2
      checks++;
      if (obs !== {1'b1, 4'h8, 32'h3, 32'h4, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sltu: got %h, required %h", obs, {1'b1, 4'h8, 32'h3, 32'h4, 1'b1, 1'b0});
      end
   endtask

   task automatic test_illegal();
      drive_one(32'h0000006F, 32'h40, 32'h55, 32'h66);              // jal
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL illegal_jal: got %h, required %h", obs, {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1});
      end
      drive_one(32'h02208133, 32'h0, 32'h55, 32'h66);               // mul: funct7 not base ISA
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL illegal_mul: got %h, required %h", obs, {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1});
      end
      drive_one(32'h40309093, 32'h0, 32'h55, 32'h66);               // slli with funct7=0100000
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL illegal_slli: got %h, required %h", obs, {1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_back_to_back();
      drive_one(32'hABCDE2B7, 32'h0, 32'h77, 32'h88);               // lui x5,0xABCDE
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h0, 32'hABCDE000, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL lui: got %h, required %h", obs, {1'b1, 4'h0, 32'h0, 32'hABCDE000, 1'b0, 1'b0});
      end
      drive_one(32'hFFC12083, 32'h0, 32'h1000, 32'h0);              // lw x1,-4(x2)
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h1000, 32'hFFFFFFFC, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL load: got %h, required %h", obs, {1'b1, 4'h0, 32'h1000, 32'hFFFFFFFC, 1'b0, 1'b0});
      end
      drive_one(32'h00312423, 32'h0, 32'h2000, 32'h9);              // sw x3,8(x2)
      checks++;
      if (obs !== {1'b1, 4'h0, 32'h2000, 32'd8, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL store: got %h, required %h", obs, {1'b1, 4'h0, 32'h2000, 32'd8, 1'b0, 1'b0});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   // Four addi (imm = k+1, rs1 = 0x100*(k+1)) with out_ready held low for 3 cycles.
   task automatic test_backpressure();
      int sent = 0;
      int rcvd = 0;
      int first_rx = -1;
      int last_rx = -1;
      logic fire_in, fire_out;
      logic [70:0] exp_v;
      for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         in_valid  = (sent < 4);
         instr     = ((sent + 1) << 20) | 32'h00000093;
         rs1_data  = 32'h100 * (sent + 1);
         if (cyc == 2) begin
            checks++;
            if (in_ready !== 1'b0 || sent != 2) begin
               errors++;
               $display("FAIL bp_in_ready_drop: in_ready=%b accepted=%0d, required 0 and 2", in_ready, sent);
            end
            checks++;
            if (obs !== {1'b1, 4'h0, 32'h100, 32'd1, 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL bp_stall_hold: got %h, required %h", obs, {1'b1, 4'h0, 32'h100, 32'd1, 1'b0, 1'b0});
            end
         end
         fire_in  = in_valid && in_ready;
         fire_out = out_valid && out_ready;
         if (fire_out) begin
            exp_v = {1'b1, 4'h0, 32'h100 * (rcvd + 1), 32'(rcvd + 1), 1'b0, 1'b0};
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL bp_item%0d: got %h, required %h", rcvd, obs, exp_v);
            end
            if (first_rx < 0) first_rx = cyc;
            last_rx = cyc;
            rcvd++;
         end
         if (fire_in) sent++;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (rcvd != 4) begin
         errors++;
         $display("FAIL bp_count: received %0d items, required 4", rcvd);
      end
      checks++;
      if (last_rx - first_rx != 3) begin
         errors++;
         $display("FAIL bp_throughput: span %0d cycles for 4 items, required 3", last_rx - first_rx);
      end
   endtask

   task automatic test_midstream_reset();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00500093;
      rs1_data  = 32'h5;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 71'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: outputs=%h in_ready=%b, required 0 and 0", obs, in_ready);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_flush%0d: out_valid=%b in_ready=%b, required 0 and 1", k, out_valid, in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_srai();
      test_slti_neg_imm();
      test_auipc();
      test_op_mix();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_midstream_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Registered decode stage that feeds the ALU. It accepts one RV32I instruction per cycle, together with its operand values, over a valid/ready handshake. For each instruction it produces the 4-bit ALU control code and the two ALU arguments, plus comparison-select and illegal flags. A 2-entry skid buffer lets the upstream pipeline run at full throughput while the downstream ALU/execute stage applies backpressure.

## Interface
- `XLEN`, default 32: operand width; only 32 is supported.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst_n` in, 1: synchronous reset, active-low.
- `in_valid` in, 1: upstream holds a valid instruction.
- `in_ready` out, 1: stage can accept an instruction this cycle.
- `instr` in, 32: RV32I instruction word.
- `pc` in, 32: address of `instr`.
- `rs1_data` in, 32: register value selected by rs1.
- `rs2_data` in, 32: register value selected by rs2.
- `out_valid` out, 1: decoded operation is presented.
- `out_ready` in, 1: downstream consumes the operation this cycle.
- `alu_ctrl` out, 4: ALU control code.
- `arg1` out, 32: ALU first argument.
- `arg2` out, 32: ALU second argument.
- `cmp_sel` out, 1: result is taken from the comparator flags (SLT/SLTU), not from the ALU result.
- `illegal` out, 1: the instruction is not supported by this stage.

## Operation
- ALU codes:
  - 0000 ADD, 0001 SUB.
  - 0010 SRL, 0011 SRA, 0100 SLL.
  - 0101 XOR, 0110 OR, 0111 AND.
  - 1000 CMP unsigned, 1001 CMP signed.
  - Codes 1010–1111 are never emitted.
- OP (0110011): funct3 maps as follows.
  - 000: ADD, or SUB when funct7[5]=1.
  - 001: SLL.
  - 010: CMP signed with cmp_sel=1.
  - 011: CMP unsigned with cmp_sel=1.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR.
  - 111: AND.
  - arg1=rs1_data, arg2=rs2_data.
  - Any funct7 other than 0000000, or other than 0100000 for SUB/SRA, is illegal.
- OP-IMM (0010011): same mapping as OP, with these differences.
  - SUB does not exist: funct3=000 is always ADD.
  - arg2 = sign-extended imm[11:0].
  - Shifts use arg2 = {27'b0, shamt}.
  - SLLI/SRLI require funct7=0000000; SRAI requires funct7=0100000; otherwise the instruction is illegal.
- LUI: ADD with arg1=0 and arg2={instr[31:12], 12'b0}.
- AUIPC: ADD with arg1=pc and arg2={instr[31:12], 12'b0}.
- LOAD (0000011): ADD with arg1=rs1_data and arg2 = sign-extended I-immediate.
- STORE (0100011): ADD with arg1=rs1_data and arg2 = sign-extended S-immediate.
- Any other opcode: illegal=1, alu_ctrl=0000, arg1=arg2=0, cmp_sel=0. The entry still flows through the handshake.
- Skid buffer:
  - Output register plus one skid register.
  - in_ready = skid register empty.
  - An input is accepted when in_valid & in_ready.
  - Accepted data goes to the output register if it is empty or being consumed this cycle; otherwise it goes to the skid register.
  - When the output register is consumed and the skid register is full, skid moves to output in the same cycle.
- Ordering: strict FIFO, no drops, no duplicates.

## Timing
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=0 while rst_n is low, both entries empty.
  - alu_ctrl=0000, arg1=arg2=0, cmp_sel=0, illegal=0.
  - in_ready=1 in the first cycle after rst_n rises.
- Latency: an accepted instruction appears on the outputs one cycle later when the stage is empty.
- Throughput: one operation per cycle while out_ready=1.
- Outputs are registered and stay stable while out_valid=1 & out_ready=0.
- Backpressure:
  - First stalled acceptance fills the skid register; in_ready drops the next cycle.
  - in_ready is a register output with no combinational path from out_ready.
- Simultaneous accept and consume with the skid register empty: the new item replaces the output register; out_valid stays 1.
- Both entries full with out_ready=1: the skid entry moves to output, in_ready=1 the next cycle.
- Reset asserted mid-stream: all in-flight entries are discarded and nothing is emitted afterward.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0; in_ready=1 one cycle after release.
- SUB: instr=0x40208133 (sub x2,x1,x2), rs1=5, rs2=7 -> next cycle alu_ctrl=0001, arg1=5, arg2=7, cmp_sel=0, illegal=0.
- SRAI: instr=0x4030D093 (srai x1,x1,3), rs1=0x80000000 -> alu_ctrl=0011, arg2=3.
- Negative immediate: instr=0xFFF0A113 (slti x2,x1,-1) -> alu_ctrl=1001, cmp_sel=1, arg2=0xFFFFFFFF.
- AUIPC: instr=0x12345017, pc=0x100 -> alu_ctrl=0000, arg1=0x100, arg2=0x12345000.
- Illegal: instr=0x0000006F (jal) -> illegal=1, alu_ctrl=0000.
- Backpressure: stream 4 ADDs with out_ready=0 for 3 cycles -> in_ready falls after 2 acceptances. Release out_ready -> all 4 outputs appear in order with no loss, then 1 per cycle.
